dmem_arbiter: RTL and testbench

- Two-master arbiter for the single-port synchronous data memory (DMEM RAM, one-cycle registered read).
- Master 0 is the multicycle CPU load/store path; master 1 is the host/loader port (matrix preload, result readback).
- Grants one access per cycle, round-robin on contention, and returns read data with a pipelined tag.
- Masks out-of-range accesses and keeps a saturating contention counter.

---
 rtl/dmem_arbiter.sv | 94 +++++++++
 tb/tb_dmem_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master round-robin arbiter for the single-port synchronous DMEM
//   clk, rstn                     clock, asynchronous active-low reset
//   m0_* / m1_*                   CPU / host request, write data, grant and read-return buses
//   ram_wr_en, ram_index,         RAM write enable, word index, write data
//   ram_entry, ram_entry_out      and registered read data (valid one cycle after index)
//   conflict_cnt                  saturating count of cycles with both masters requesting
//   oor_err                       sticky flag: an out-of-range access was accepted
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 5300,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_index,
  output logic [DATA_W-1:0] ram_entry,
  input  logic [DATA_W-1:0] ram_entry_out,
  output logic [CNT_W-1:0]  conflict_cnt,
  output logic              oor_err
);
  // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
  logic              last_gnt_q, last_gnt_d;
  logic              tag_v_q, tag_v_d;
  logic              tag_id_q, tag_id_d;
  logic              tag_oor_q, tag_oor_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              oor_q, oor_d;
  logic              sel1, acc, win_we, win_oor;
  logic [ADDR_W-1:0] win_addr;
  // m1 wins when alone, or on contention when m0 was the last accepted master
  always_comb begin
    sel1      = m1_req & (~m0_req | ~last_gnt_q);
    m1_gnt    = sel1;
    m0_gnt    = m0_req & ~sel1;
    acc       = m0_gnt | m1_gnt;
    win_addr  = sel1 ? m1_addr : m0_addr;
    win_we    = sel1 ? m1_we : m0_we;
    win_oor   = {1'b0, win_addr} >= LIMIT;
    ram_index = win_addr;
    ram_entry = sel1 ? m1_wdata : m0_wdata;
    ram_wr_en = acc & win_we & ~win_oor;
  end
  always_comb begin
    last_gnt_d = acc ? sel1 : last_gnt_q;
    tag_v_d    = acc & ~win_we;
    tag_id_d   = sel1;
    tag_oor_d  = win_oor;
    cnt_d      = (m0_req & m1_req & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    oor_d      = oor_q | (acc & win_oor);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_gnt_q <= 1'b1;
      tag_v_q    <= 1'b0;
      tag_id_q   <= 1'b0;
      tag_oor_q  <= 1'b0;
      cnt_q      <= '0;
      oor_q      <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
      tag_v_q    <= tag_v_d;
      tag_id_q   <= tag_id_d;
      tag_oor_q  <= tag_oor_d;
      cnt_q      <= cnt_d;
      oor_q      <= oor_d;
    end
  end
  // Out-of-range reads still return a valid strobe, but with zero data
  always_comb begin
    m0_rvalid    = tag_v_q & ~tag_id_q;
    m1_rvalid    = tag_v_q & tag_id_q;
    m0_rdata     = (m0_rvalid & ~tag_oor_q) ? ram_entry_out : '0;
    m1_rdata     = (m1_rvalid & ~tag_oor_q) ? ram_entry_out : '0;
    conflict_cnt = cnt_q;
    oor_err      = oor_q;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural synchronous RAM
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [12:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_wr_en;
  logic [12:0] ram_index;
  logic [31:0] ram_entry;
  logic [31:0] ram_entry_out = '0;
  logic [15:0] conflict_cnt;
  logic        oor_err;
  logic [31:0] mem [0:8191];
  logic [31:0] q0[$], q1[$];
  logic        no_push = 1'b0;
  int          n_chk = 0, n_fail = 0;

  dmem_arbiter dut (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_wr_en(ram_wr_en), .ram_index(ram_index), .ram_entry(ram_entry),
    .ram_entry_out(ram_entry_out), .conflict_cnt(conflict_cnt), .oor_err(oor_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_index] <= ram_entry;
    ram_entry_out <= mem[ram_index];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("one_rvalid", {31'b0, m0_rvalid & m1_rvalid}, 32'd0);
    check("m0_rvalid", {31'b0, m0_rvalid}, {31'b0, m0_rvalid & (q0.size() != 0)});
    check("m1_rvalid", {31'b0, m1_rvalid}, {31'b0, m1_rvalid & (q1.size() != 0)});
    if (m0_rvalid && q0.size() != 0) check("m0_rdata", m0_rdata, q0.pop_front());
    else check("m0_rdata_idle", m0_rdata, 32'd0);
    if (m1_rvalid && q1.size() != 0) check("m1_rdata", m1_rdata, q1.pop_front());
    else check("m1_rdata_idle", m1_rdata, 32'd0);
  end

  task automatic cyc(input logic r0, w0, input logic [12:0] a0, input logic [31:0] d0,
                     input logic r1, w1, input logic [12:0] a1, input logic [31:0] d1,
                     input logic eg0, eg1, ewr, input logic [31:0] ex0, ex1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    @(negedge clk);
    check("m0_gnt", {31'b0, m0_gnt}, {31'b0, eg0});
    check("m1_gnt", {31'b0, m1_gnt}, {31'b0, eg1});
    check("ram_wr_en", {31'b0, ram_wr_en}, {31'b0, ewr});
    if (!no_push && eg0 && !w0) q0.push_back(ex0);
    if (!no_push && eg1 && !w1) q1.push_back(ex1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle(0);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_cnt", {16'b0, conflict_cnt}, 32'd0);
    check("rst_oor", {31'b0, oor_err}, 32'd0);
    check("rst_rvalid", {30'b0, m0_rvalid, m1_rvalid}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    mem[1] = 32'hA1A1_0001;
    mem[2] = 32'hB2B2_0002;
    mem[5300] = 32'h9999_9999;
    do_reset();
    // m1 write alone, then m0 reads it back
    cyc(0,0,0,0, 1,1,5,32'hDEADBEEF, 0,1,1, 0,0);
    cyc(1,0,5,0, 0,0,0,0, 1,0,0, 32'hDEADBEEF,0);
    idle(2);
    // contention right after reset: m0 first, then alternating
    do_reset();
    cyc(1,0,1,0, 1,0,2,0, 1,0,0, 32'hA1A1_0001,0);
    cyc(1,0,1,0, 1,0,2,0, 0,1,0, 0,32'hB2B2_0002);
    cyc(1,0,1,0, 1,0,2,0, 1,0,0, 32'hA1A1_0001,0);
    cyc(1,0,1,0, 1,0,2,0, 0,1,0, 0,32'hB2B2_0002);
    idle(1);
    check("cnt_after4", {16'b0, conflict_cnt}, 32'd4);
    idle(1);
    // write then read the same word back-to-back
    cyc(1,1,7,32'h11, 0,0,0,0, 1,0,1, 0,0);
    cyc(1,0,7,0, 0,0,0,0, 1,0,0, 32'h11,0);
    idle(2);
    // out-of-range write dropped, read returns zero, error sticks
    cyc(0,0,0,0, 1,1,5300,32'h22, 0,1,0, 0,0);
    check("oor_set", {31'b0, oor_err}, 32'd1);
    cyc(0,0,0,0, 1,0,5300,0, 0,1,0, 0,32'd0);
    idle(3);
    check("oor_sticky", {31'b0, oor_err}, 32'd1);
    check("oor_mem", mem[5300], 32'h9999_9999);
    // reset lands between accept and return: read is discarded
    no_push = 1'b1;
    cyc(1,0,1,0, 0,0,0,0, 1,0,0, 0,0);
    no_push = 1'b0;
    rstn = 1'b0;
    m0_req = 1'b0;
    @(negedge clk);
    check("rst_mid_rvalid", {31'b0, m0_rvalid}, 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst2_oor", {31'b0, oor_err}, 32'd0);
    check("rst2_cnt", {16'b0, conflict_cnt}, 32'd0);
    @(posedge clk);
    #1;
    cyc(1,0,2,0, 1,0,1,0, 1,0,0, 32'hB2B2_0002,0);
    idle(2);
    // saturation of the contention counter
    do_reset();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 0; m0_wdata = 32'h1;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 0; m1_wdata = 32'h2;
    repeat (65534) @(posedge clk);
    #1;
    check("cnt_pre_sat", {16'b0, conflict_cnt}, 32'h0000_FFFE);
    repeat (1) @(posedge clk);
    #1;
    check("cnt_sat", {16'b0, conflict_cnt}, 32'h0000_FFFF);
    repeat (6) @(posedge clk);
    #1;
    check("cnt_nowrap", {16'b0, conflict_cnt}, 32'h0000_FFFF);
    idle(2);
    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
